// File: rtl/sysid_checker.sv
// Reads the ID and build-timestamp words from an Avalon-MM sysid slave and compares
// them against the expected values, optionally re-running the check periodically.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd67108864,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1414448401,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1,
  parameter logic [23:0] RECHECK_PERIOD     = 24'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sid_address,
  output logic        sid_read,
  input  logic [31:0] sid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  mismatch_count
);

  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CMP} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

  state_t      state, state_next;
  logic [2:0]  wait_cnt;
  logic [23:0] recheck_cnt;
  logic        recheck_armed;
  logic        auto_pend;
  logic        recheck_hit;
  logic        launch;
  logic        wait_end;
  logic        cap_id;
  logic        cap_ts;

  // The recheck fires on the IDLE cycle where the counter would step down to zero,
  // so the new RD_ID lands exactly RECHECK_PERIOD cycles after the done pulse.
  always_comb begin
    recheck_hit = recheck_armed && (recheck_cnt <= 24'd1);
    launch      = (state == IDLE) && (start || auto_pend || recheck_hit);
    wait_end    = (wait_cnt == WAIT_LAST);
    cap_id      = (READ_LATENCY == 0) ? (state == RD_ID) : ((state == WT_ID) && wait_end);
    cap_ts      = (READ_LATENCY == 0) ? (state == RD_TS) : ((state == WT_TS) && wait_end);

    state_next  = state;
    case (state)
      IDLE:    if (launch) state_next = RD_ID;
      RD_ID:   state_next = (READ_LATENCY == 0) ? RD_TS : WT_ID;
      WT_ID:   if (wait_end) state_next = RD_TS;
      RD_TS:   state_next = (READ_LATENCY == 0) ? CMP : WT_TS;
      WT_TS:   if (wait_end) state_next = CMP;
      CMP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    sid_read    = (state == RD_ID) || (state == RD_TS);
    sid_address = (state == RD_TS);
    busy        = (state != IDLE);
    done        = (state == CMP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_next;
      if ((state == WT_ID) || (state == WT_TS))
        wait_cnt <= wait_end ? 3'd0 : wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;
    end
  end

  // A start-launched check disarms the recheck; it is reloaded at the next done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_pend     <= AUTO_START;
      recheck_armed <= 1'b0;
      recheck_cnt   <= 24'd0;
    end else begin
      if (launch)
        auto_pend <= 1'b0;
      if (state == CMP) begin
        recheck_armed <= (RECHECK_PERIOD != 24'd0);
        recheck_cnt   <= RECHECK_PERIOD - 24'd1;
      end else if (launch) begin
        recheck_armed <= 1'b0;
      end else if ((state == IDLE) && recheck_armed) begin
        recheck_cnt <= recheck_cnt - 24'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_value       <= 32'd0;
      ts_value       <= 32'd0;
      id_ok          <= 1'b0;
      ts_ok          <= 1'b0;
      mismatch_count <= 8'd0;
    end else begin
      if (cap_id)
        id_value <= sid_readdata;
      if (cap_ts)
        ts_value <= sid_readdata;
      if (state == CMP) begin
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
        if (((id_value != EXPECTED_ID) || (ts_value != EXPECTED_TIMESTAMP)) &&
            (mismatch_count != 8'd255))
          mismatch_count <= mismatch_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: four instances (latency 0/2/0/3, one rechecking, one
// auto-starting) each fed by a small latency-accurate sysid slave model.
module tb_sysid_checker;

  localparam logic [31:0] EID = 32'd67108864;
  localparam logic [31:0] ETS = 32'd1414448401;
  localparam int LATS [4] = '{0, 2, 0, 3};

  logic        clock;
  logic        reset_s [4];
  logic        start_s [4];
  logic        addr_s  [4];
  logic        read_s  [4];
  logic        busy_s  [4];
  logic        done_s  [4];
  logic        idok_s  [4];
  logic        tsok_s  [4];
  logic [31:0] rdata_s [4];
  logic [31:0] idv_s   [4];
  logic [31:0] tsv_s   [4];
  logic [7:0]  mc_s    [4];

  logic [31:0] id_word [4];
  logic [31:0] ts_word [4];
  logic [7:0]  vh [4] = '{default: '0};
  logic [7:0]  ah [4] = '{default: '0};

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b0), .RECHECK_PERIOD(24'd0)) u0 (
    .clock(clock), .reset(reset_s[0]), .start(start_s[0]), .sid_address(addr_s[0]),
    .sid_read(read_s[0]), .sid_readdata(rdata_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .id_ok(idok_s[0]), .ts_ok(tsok_s[0]), .id_value(idv_s[0]), .ts_value(tsv_s[0]),
    .mismatch_count(mc_s[0]));

  sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0), .RECHECK_PERIOD(24'd0)) u1 (
    .clock(clock), .reset(reset_s[1]), .start(start_s[1]), .sid_address(addr_s[1]),
    .sid_read(read_s[1]), .sid_readdata(rdata_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .id_ok(idok_s[1]), .ts_ok(tsok_s[1]), .id_value(idv_s[1]), .ts_value(tsv_s[1]),
    .mismatch_count(mc_s[1]));

  sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b0), .RECHECK_PERIOD(24'd10)) u2 (
    .clock(clock), .reset(reset_s[2]), .start(start_s[2]), .sid_address(addr_s[2]),
    .sid_read(read_s[2]), .sid_readdata(rdata_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .id_ok(idok_s[2]), .ts_ok(tsok_s[2]), .id_value(idv_s[2]), .ts_value(tsv_s[2]),
    .mismatch_count(mc_s[2]));

  sysid_checker #(.READ_LATENCY(3), .AUTO_START(1'b1), .RECHECK_PERIOD(24'd0)) u3 (
    .clock(clock), .reset(reset_s[3]), .start(start_s[3]), .sid_address(addr_s[3]),
    .sid_read(read_s[3]), .sid_readdata(rdata_s[3]), .busy(busy_s[3]), .done(done_s[3]),
    .id_ok(idok_s[3]), .ts_ok(tsok_s[3]), .id_value(idv_s[3]), .ts_value(tsv_s[3]),
    .mismatch_count(mc_s[3]));

  // Slave model: data is valid only in the cycle exactly LAT cycles after the strobe.
  always @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      vh[k] <= {vh[k][6:0], read_s[k]};
      ah[k] <= {ah[k][6:0], addr_s[k]};
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      logic [8:0] vhist;
      logic [8:0] ahist;
      vhist = {vh[k], read_s[k]};
      ahist = {ah[k], addr_s[k]};
      rdata_s[k] = 32'hDEADBEEF;
      if (vhist[LATS[k]])
        rdata_s[k] = ahist[LATS[k]] ? ts_word[k] : id_word[k];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int k);
    start_s[k] = 1'b1;
    @(negedge clock);
    start_s[k] = 1'b0;
  endtask

  task automatic runCheck(input int k, output int rd1, output int rd2, output int dn,
                          output logic a1, output logic a2);
    int cyc;
    rd1 = -1; rd2 = -1; dn = -1; a1 = 1'bx; a2 = 1'bx;
    applyStimulus(k);
    cyc = 1;
    while (cyc <= 40 && dn < 0) begin
      if (read_s[k]) begin
        if (rd1 < 0) begin rd1 = cyc; a1 = addr_s[k]; end
        else if (rd2 < 0) begin rd2 = cyc; a2 = addr_s[k]; end
      end
      if (done_s[k]) dn = cyc;
      else begin @(negedge clock); cyc++; end
    end
  endtask

  task automatic checkTiming(input string tag, input int k, input int lat);
    int rd1, rd2, dn;
    logic a1, a2;
    runCheck(k, rd1, rd2, dn, a1, a2);
    checkOutput({tag, "_rd1_cycle"}, rd1, 1);
    checkOutput({tag, "_rd1_addr"}, 32'(a1), 32'd0);
    checkOutput({tag, "_rd2_cycle"}, rd2, 2 + lat);
    checkOutput({tag, "_rd2_addr"}, 32'(a2), 32'd1);
    checkOutput({tag, "_done_cycle"}, dn, 3 + 2 * lat);
    @(negedge clock);
    checkOutput({tag, "_busy_after"}, 32'(busy_s[k]), 32'd0);
  endtask

  task automatic cyclesToRead(input int k, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!read_s[k] && n < 40);
    if (!read_s[k]) n = -1;
  endtask

  task automatic cyclesToDone(input int k, output int n);
    n = 0;
    do begin @(negedge clock); n++; end while (!done_s[k] && n < 40);
    if (!done_s[k]) n = -1;
  endtask

  task automatic checkIdleFlags(input string tag, input int k);
    checkOutput({tag, "_flags"}, 32'({busy_s[k], done_s[k], read_s[k], addr_s[k],
                                      idok_s[k], tsok_s[k], mc_s[k]}), 32'd0);
    checkOutput({tag, "_id_value"}, idv_s[k], 32'd0);
    checkOutput({tag, "_ts_value"}, tsv_s[k], 32'd0);
  endtask

  typedef struct {
    logic [31:0] idw;
    logic [31:0] tsw;
    logic        idok;
    logic        tsok;
    logic        inc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, n_done, timeouts;
    logic [7:0] exp_mc;

    vecs[0] = '{EID,          ETS,          1'b1, 1'b1, 1'b0};
    vecs[1] = '{32'h04000001, ETS,          1'b0, 1'b1, 1'b1};
    vecs[2] = '{EID,          32'd0,        1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{EID,          ETS,          1'b1, 1'b1, 1'b0};

    for (int k = 0; k < 4; k++) begin
      reset_s[k] = 1'b1;
      start_s[k] = 1'b0;
      id_word[k] = EID;
      ts_word[k] = ETS;
    end

    @(negedge clock);
    @(negedge clock);
    for (int k = 0; k < 4; k++) checkIdleFlags($sformatf("reset_u%0d", k), k);
    for (int k = 0; k < 4; k++) reset_s[k] = 1'b0;

    $display("[TB] auto-start after reset, latency 3");
    cyclesToRead(3, n);
    checkOutput("auto_first_read", n, 1);
    cyclesToDone(3, n);
    checkOutput("auto_done", n, 8);
    @(negedge clock);
    checkOutput("auto_id_ok", 32'(idok_s[3]), 32'd1);
    checkOutput("auto_ts_ok", 32'(tsok_s[3]), 32'd1);

    $display("[TB] table-driven checks, latency 0");
    exp_mc = 8'd0;
    for (int i = 0; i < 5; i++) begin
      id_word[0] = vecs[i].idw;
      ts_word[0] = vecs[i].tsw;
      checkTiming($sformatf("vec%0d", i), 0, 0);
      if (vecs[i].inc) exp_mc = exp_mc + 8'd1;
      checkOutput($sformatf("vec%0d_id_ok", i), 32'(idok_s[0]), 32'(vecs[i].idok));
      checkOutput($sformatf("vec%0d_ts_ok", i), 32'(tsok_s[0]), 32'(vecs[i].tsok));
      checkOutput($sformatf("vec%0d_id_value", i), idv_s[0], vecs[i].idw);
      checkOutput($sformatf("vec%0d_ts_value", i), tsv_s[0], vecs[i].tsw);
      checkOutput($sformatf("vec%0d_mismatch", i), 32'(mc_s[0]), 32'(exp_mc));
    end
    repeat (5) @(negedge clock);
    checkOutput("hold_id_value", idv_s[0], EID);
    checkOutput("hold_id_ok", 32'(idok_s[0]), 32'd1);

    $display("[TB] start during RD_TS is ignored");
    applyStimulus(0);
    @(negedge clock);
    checkOutput("rdts_addr", 32'(addr_s[0]), 32'd1);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    n_done = 0;
    for (int c = 0; c < 13; c++) begin
      if (done_s[0]) n_done++;
      @(negedge clock);
    end
    checkOutput("rdts_single_done", n_done, 1);
    checkOutput("rdts_busy_end", 32'(busy_s[0]), 32'd0);

    $display("[TB] latency 2 with bad ID");
    id_word[1] = 32'd0;
    checkTiming("lat2", 1, 2);
    checkOutput("lat2_id_ok", 32'(idok_s[1]), 32'd0);
    checkOutput("lat2_ts_ok", 32'(tsok_s[1]), 32'd1);
    checkOutput("lat2_id_value", idv_s[1], 32'd0);
    checkOutput("lat2_ts_value", tsv_s[1], ETS);
    checkOutput("lat2_mismatch", 32'(mc_s[1]), 32'd1);

    $display("[TB] periodic recheck, period 10");
    begin
      int rd1, rd2, dn;
      logic a1, a2;
      runCheck(2, rd1, rd2, dn, a1, a2);
      checkOutput("rc_first_done", dn, 3);
    end
    for (int r = 0; r < 3; r++) begin
      cyclesToRead(2, n);
      checkOutput($sformatf("rc%0d_gap", r), n, 10);
      cyclesToDone(2, n);
      checkOutput($sformatf("rc%0d_done", r), n, 2);
    end
    repeat (4) @(negedge clock);
    applyStimulus(2);
    checkOutput("rc_start_precedence", 32'(read_s[2]), 32'd1);
    cyclesToDone(2, n);
    checkOutput("rc_start_done", n, 2);
    cyclesToRead(2, n);
    checkOutput("rc_reload_gap", n, 10);
    checkOutput("rc_mismatch", 32'(mc_s[2]), 32'd0);

    $display("[TB] reset during WT_TS, latency 3");
    applyStimulus(3);
    repeat (5) @(negedge clock);
    checkOutput("wtts_busy", 32'(busy_s[3]), 32'd1);
    reset_s[3] = 1'b1;
    #1;
    checkIdleFlags("wtts_reset", 3);
    repeat (3) @(negedge clock);
    reset_s[3] = 1'b0;
    cyclesToRead(3, n);
    checkOutput("wtts_auto_read", n, 1);
    cyclesToDone(3, n);
    checkOutput("wtts_auto_done", n, 8);
    @(negedge clock);
    checkOutput("wtts_id_ok", 32'(idok_s[3]), 32'd1);
    checkOutput("wtts_ts_ok", 32'(tsok_s[3]), 32'd1);
    checkOutput("wtts_id_value", idv_s[3], EID);
    checkOutput("wtts_mismatch", 32'(mc_s[3]), 32'd0);

    $display("[TB] 300 failing checks saturate the mismatch counter");
    id_word[0] = 32'h0BADF00D;
    timeouts = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0);
      cyclesToDone(0, n);
      if (n < 0) timeouts++;
      @(negedge clock);
    end
    checkOutput("sat_timeouts", timeouts, 0);
    checkOutput("sat_mismatch", 32'(mc_s[0]), 32'd255);
    checkOutput("sat_id_ok", 32'(idok_s[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
